// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg : shared encodings and defaults for the highway/country light controller
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package tlc_pkg;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } phase_t;

  typedef enum logic [1:0] {
    LAMP_G = 2'b00,
    LAMP_Y = 2'b01,
    LAMP_R = 2'b10
  } lamp_t;

  typedef enum logic [1:0] {
    LOAD    = 2'b00,
    COUNT   = 2'b01,
    EXPIRED = 2'b10,
    FIRED   = 2'b11
  } timer_state_t;

  localparam int DEF_TICK_DIV     = 50_000_000;
  localparam int DEF_DEBOUNCE_CYC = 500_000;
  localparam int DEF_DWELL_S0     = 10;
  localparam int DEF_DWELL_S1     = 3;
  localparam int DEF_DWELL_S2     = 1;
  localparam int DEF_DWELL_S3     = 5;
  localparam int DEF_DWELL_S4     = 3;
  localparam int DEF_CNT_W        = 6;

  // Greens wait on the side-road sensor; yellows, all-red and illegal phases always advance.
  function automatic logic phase_gate(input logic [2:0] ph, input logic sensor);
    case (ph)
      S0:      phase_gate = sensor;
      S3:      phase_gate = ~sensor;
      default: phase_gate = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_debounce.sv
// ---------------------------------------------------------------------------
// tlc_debounce : 2-flop synchroniser plus stability counter for the car sensor
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tlc_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      // Output follows only after DEBOUNCE_CYC consecutive disagreeing cycles.
      if (sync != dout) begin
        if (cnt == CNT_MAX) begin
          dout <= sync;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlc_phase_timer.sv
// ---------------------------------------------------------------------------
// tlc_phase_timer : 1 s prescaler, phase dwell timer and step pulse generator
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tlc_phase_timer
  import tlc_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int DWELL_S0     = DEF_DWELL_S0,
  parameter int DWELL_S1     = DEF_DWELL_S1,
  parameter int DWELL_S2     = DEF_DWELL_S2,
  parameter int DWELL_S3     = DEF_DWELL_S3,
  parameter int DWELL_S4     = DEF_DWELL_S4,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             sensor_raw,
  input  logic [2:0]       ctl_state,
  output logic             step,
  output logic             sensor_db,
  output logic [CNT_W-1:0] secs_left,
  output logic             tick
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  timer_state_t       state, state_nx;
  logic [2:0]         prev_state, prev_nx;
  logic [CNT_W-1:0]   secs_nx;
  logic [PRESC_W-1:0] presc, presc_nx;
  logic               tick_nx;
  logic               step_nx;
  logic               phase_chg;

  function automatic logic [CNT_W-1:0] dwell_of(input logic [2:0] ph);
    case (ph)
      S0:      dwell_of = CNT_W'(DWELL_S0);
      S1:      dwell_of = CNT_W'(DWELL_S1);
      S2:      dwell_of = CNT_W'(DWELL_S2);
      S3:      dwell_of = CNT_W'(DWELL_S3);
      S4:      dwell_of = CNT_W'(DWELL_S4);
      default: dwell_of = CNT_W'(1);
    endcase
  endfunction

  tlc_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk   (CLOCK_50),
    .rst_n (KEY0),
    .din   (sensor_raw),
    .dout  (sensor_db)
  );

  // KEY0 is expected to be released synchronously to CLOCK_50 by the board reset logic.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state      <= LOAD;
      prev_state <= 3'b000;
      secs_left  <= CNT_W'(DWELL_S0);
      presc      <= '0;
      tick       <= 1'b0;
      step       <= 1'b0;
    end else begin
      state      <= state_nx;
      prev_state <= prev_nx;
      secs_left  <= secs_nx;
      presc      <= presc_nx;
      tick       <= tick_nx;
      step       <= step_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    prev_nx   = prev_state;
    secs_nx   = secs_left;
    step_nx   = 1'b0;
    phase_chg = (ctl_state != prev_state);

    if (presc == PRESC_MAX) begin
      presc_nx = '0;
      tick_nx  = 1'b1;
    end else begin
      presc_nx = presc + 1'b1;
      tick_nx  = 1'b0;
    end

    // A phase change beats everything, including a coincident tick; zeroing the
    // prescaler here gives the new phase a full first second.
    if (phase_chg) begin
      prev_nx  = ctl_state;
      state_nx = LOAD;
      presc_nx = '0;
      tick_nx  = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          secs_nx  = dwell_of(ctl_state);
          state_nx = COUNT;
        end
        COUNT: begin
          if (secs_left == '0) begin
            state_nx = EXPIRED;
          end else if (tick) begin
            secs_nx = secs_left - 1'b1;
            if (secs_left == CNT_W'(1)) begin
              state_nx = EXPIRED;
            end
          end
        end
        EXPIRED: begin
          if (phase_gate(ctl_state, sensor_db)) begin
            step_nx  = 1'b1;
            state_nx = FIRED;
          end
        end
        FIRED: begin
          secs_nx = '0;
        end
        default: begin
          state_nx = LOAD;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
